button_inport: RTL and testbench

BUTTON_INPORT -- requirements
Module: button_inport

---
 rtl/button_inport.sv | 118 +++++++++++
 tb/tb_button_inport.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/button_inport.sv
// ============================================================================
// Module   : button_inport
// Purpose  : Debounced push-button input port. Each raw pin is synchronized,
//            debounced into a LEVEL register, and rising level transitions
//            latch sticky bits in an EVENT register that clears on read.
// Options  : INPORT_IRQ_EN - when defined, adds the irq output (registered
//            OR of all pending event bits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_inport #(
  parameter int N_PINS          = 4,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic              clk_core,
  input  logic              resetn,
  input  logic [N_PINS-1:0] pins,
  input  logic              rd,
  input  logic              addr,
`ifdef INPORT_IRQ_EN
  output logic              irq,
`endif
  output logic [15:0]       rdata
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_PINS-1:0] r_sync1;
  logic [N_PINS-1:0] r_sync2;
  logic [N_PINS-1:0] r_level;
  logic [N_PINS-1:0] r_event;
  logic [15:0]       r_rdata;

  logic [N_PINS-1:0] w_level_next;
  logic [N_PINS-1:0] w_rise;
  logic [N_PINS-1:0] w_clear;
  logic [N_PINS-1:0] w_event_next;
  logic [15:0]       w_read_val;

  // Two-flop synchronizer on the raw asynchronous pins
  always_ff @(posedge clk_core or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pins;
      r_sync2 <= r_sync1;
    end
  end

  // Per-pin debounce: a level is accepted only after it differs from the
  // current level for DEBOUNCE_CYCLES consecutive edges; any agreement
  // restarts the count, so glitches never accumulate.
  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_done;

    assign w_diff          = r_sync2[i] ^ r_level[i];
    assign w_done          = w_diff && (r_cnt == c_cnt_max);
    assign w_level_next[i] = w_done ? r_sync2[i] : r_level[i];

    // Stable-cycle counter for this pin
    always_ff @(posedge clk_core or negedge resetn) begin
      if (!resetn) begin
        r_cnt <= '0;
      end else if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // A new rising edge wins over a simultaneous clearing read, so the clear
  // mask is the pre-edge event value and the rise is OR-ed in afterwards.
  assign w_rise       = w_level_next & ~r_level;
  assign w_clear      = (rd && addr) ? r_event : '0;
  assign w_event_next = (r_event & ~w_clear) | w_rise;
  assign w_read_val   = addr ? 16'(r_event) : 16'(r_level);

  // Level, event and read-data registers
  always_ff @(posedge clk_core or negedge resetn) begin
    if (!resetn) begin
      r_level <= '0;
      r_event <= '0;
      r_rdata <= '0;
    end else begin
      r_level <= w_level_next;
      r_event <= w_event_next;
      if (rd) begin
        r_rdata <= w_read_val;
      end
    end
  end

  assign rdata = r_rdata;

`ifdef INPORT_IRQ_EN
  logic r_irq;

  // Interrupt tracks the next event value so it moves on the same edge
  always_ff @(posedge clk_core or negedge resetn) begin
    if (!resetn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_event_next;
    end
  end

  assign irq = r_irq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_inport.sv
// ============================================================================
// Module   : tb_button_inport
// Purpose  : Directed self-checking bench for button_inport with
//            N_PINS=4, DEBOUNCE_CYCLES=4. Pin changes are applied just after
//            a reference edge (edge 0); a steady change reaches LEVEL on
//            edge 6, which a read on edge 7 returns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_inport;

  localparam int N_PINS = 4;
  localparam int DEB    = 4;

  logic              clk_core = 1'b0;
  logic              resetn   = 1'b0;
  logic [N_PINS-1:0] pins     = '0;
  logic              rd       = 1'b0;
  logic              addr     = 1'b0;
  logic [15:0]       rdata;
`ifdef INPORT_IRQ_EN
  logic              irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  button_inport #(
    .N_PINS          (N_PINS),
    .DEBOUNCE_CYCLES (DEB)
  ) u_dut (
    .clk_core (clk_core),
    .resetn   (resetn),
    .pins     (pins),
    .rd       (rd),
    .addr     (addr),
`ifdef INPORT_IRQ_EN
    .irq      (irq),
`endif
    .rdata    (rdata)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_core);
      #1;
    end
  endtask

  // One read consumes one edge; rdata is checked just after that edge
  task automatic rd_reg(input logic a, input string tag, input logic [15:0] exp);
    rd   = 1'b1;
    addr = a;
    tick(1);
    rd   = 1'b0;
    addr = 1'b0;
    check(tag, rdata, exp);
  endtask

  initial begin
    // Reset with all pins held high
    resetn = 1'b0;
    pins   = 4'hF;
    tick(3);
    check("reset_rdata", rdata, 16'h0000);
`ifdef INPORT_IRQ_EN
    check("reset_irq", {15'b0, irq}, 16'h0000);
`endif
    resetn = 1'b1;                       // edge 0 reference
    rd_reg(1'b0, "rst_first_edge", 16'h0000);   // edge 1
    tick(4);                                    // edges 2..5
    rd_reg(1'b0, "rst_lvl_e6", 16'h0000);       // level not yet visible
    rd_reg(1'b0, "rst_lvl_e7", 16'h000F);
    rd_reg(1'b1, "rst_evt", 16'h000F);
    tick(3);
    check("rdata_hold", rdata, 16'h000F);
    rd_reg(1'b1, "rst_evt_cleared", 16'h0000);

    // Falling levels must not raise events
    pins = 4'h0;
    tick(8);
    rd_reg(1'b0, "fall_lvl", 16'h0000);
    rd_reg(1'b1, "fall_evt", 16'h0000);

    // Debounce latency on pin 0
    pins = 4'h1;
    tick(5);
    rd_reg(1'b0, "deb_lvl_e6", 16'h0000);
    rd_reg(1'b0, "deb_lvl_e7", 16'h0001);
    rd_reg(1'b1, "deb_evt", 16'h0001);

    // Three-edge glitch on pin 1 is rejected
    pins = 4'h3;
    tick(3);
    pins = 4'h1;
    tick(8);
    rd_reg(1'b0, "glitch_lvl", 16'h0001);
    rd_reg(1'b1, "glitch_evt", 16'h0000);

    // Clear-on-read with events on pins 0 and 2
    pins = 4'h0;
    tick(8);
    rd_reg(1'b1, "cor_pre_evt", 16'h0000);
    rd_reg(1'b0, "cor_pre_lvl", 16'h0000);
    pins = 4'h5;
    tick(8);
`ifdef INPORT_IRQ_EN
    check("cor_irq_set", {15'b0, irq}, 16'h0001);
`endif
    rd_reg(1'b1, "cor_first", 16'h0005);
`ifdef INPORT_IRQ_EN
    check("cor_irq_clr", {15'b0, irq}, 16'h0000);
`endif
    rd_reg(1'b1, "cor_second", 16'h0000);

    // Pin 3 level rises on the same edge as a clearing read
    pins = 4'hD;
    tick(5);
    rd_reg(1'b1, "sim_first", 16'h0000);
`ifdef INPORT_IRQ_EN
    check("sim_irq_set", {15'b0, irq}, 16'h0001);
`endif
    rd_reg(1'b1, "sim_second", 16'h0008);
`ifdef INPORT_IRQ_EN
    check("sim_irq_clr", {15'b0, irq}, 16'h0000);
`endif

    // Reset in the middle of a pin 2 debounce discards the partial count
    pins = 4'h0;
    tick(8);
    rd_reg(1'b1, "mid_pre_evt", 16'h0000);
    pins = 4'h4;
    tick(4);                              // counter at 2
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(5);
    rd_reg(1'b0, "mid_lvl_r6", 16'h0000);
    rd_reg(1'b0, "mid_lvl_r7", 16'h0004);
    rd_reg(1'b1, "mid_evt", 16'h0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
